player_ctrl_grid: RTL and testbench
===================================

Name: player_ctrl_grid

Overview:
Parametrised successor to the single-player movement/attack FSM. It owns one player's grid position, facing, sword and idle animation on a configurable grid. New behaviour:
- hold-to-repeat movement
- attack cooldown
- off-grid sword suppression
- respawn load from the game state controller

It sits between the input debouncer and the game state controller / sprite renderer. All game-time behaviour advances only on the frame tick `trigger`.

Parameters:
GRID_W, 16, grid columns; x range 0..GRID_W-1
GRID_H, 12, grid rows; y range Y_MIN..GRID_H-1
Y_MIN, 1, topmost legal row (row 0 reserved for HUD)
XW, 4, x coordinate width, >= clog2(GRID_W)
YW, 4, y coordinate width, >= clog2(GRID_H)
ATTACK_FRAMES, 3, ticks sword stays visible (>=1)
COOLDOWN_FRAMES, 4, ticks after attack end during which attack presses are ignored
REPEAT_DELAY, 8, ticks a direction must be held before auto-repeat starts
REPEAT_RATE, 3, ticks between auto-repeat steps
ANIM_PERIOD, 8, ticks per idle sprite frame
SPAWN_X, 1, reset x
SPAWN_Y, 3, reset y

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low
trigger  in  1  one-clk frame tick
btn  in  5  held levels {attack,right,left,down,up}
spawn_valid  in  1  one-clk respawn request
spawn_x  in  XW  respawn column
spawn_y  in  YW  respawn row
player_x  out  XW  current column
player_y  out  YW  current row
player_orientation  out  2  sprite mirror: 01 right, 11 left
player_direction  out  2  facing: 00 up, 01 right, 10 down, 11 left
player_sprite  out  4  sprite index
sword_x  out  XW  sword column
sword_y  out  YW  sword row
sword_visible  out  1  sword drawn/active
sword_orientation  out  2  sword facing, same coding as direction
attacking  out  1  high in ATTACK state

Behaviour:
- Reset (reset==0 on a clk edge):
  - player_x=SPAWN_X, player_y=SPAWN_Y; orientation=01, direction=01.
  - sprite=4'd2; sword_x=0, sword_y=0, sword_visible=0, sword_orientation=01; attacking=0.
  - state=IDLE; all counters 0; previous-button register 0.
- All state and outputs change only on clk edges with trigger=1. The exception is spawn_valid, which acts on any clk.
- Button sampling per tick:
  - press = btn & ~btn_prev; btn_prev<=btn.
  - Direction priority for simultaneous bits: up > down > left > right. Only one step per tick; no diagonals.
- States:
  - IDLE (move allowed).
  - ATTACK.
  - Cooldown counter runs independently of state.
- IDLE, per tick:
  - If press[4] and cooldown==0 -> ATTACK.
    - Facing = highest-priority held direction, else current direction. Set player_direction to it (orientation too if left/right).
    - sword position = player ± 1 in facing axis; sword_orientation=facing; attack counter=0.
    - sword_visible=1 only if the target cell is in range (x 0..GRID_W-1, y Y_MIN..GRID_H-1), else 0.
    - attacking=1.
  - Else, on a direction press (or auto-repeat fire):
    - Step one cell if the destination is in range.
    - Direction/orientation update even when blocked at the boundary; position holds.
    - Right/left set orientation 01/11; up/down leave orientation unchanged.
  - Auto-repeat:
    - hold counter increments each tick while the same single direction stays held; resets on release or direction change.
    - First step is on press. Repeat steps fire when hold counter == REPEAT_DELAY, then every REPEAT_RATE ticks after.
- ATTACK:
  - No movement; sword position frozen; counter increments each tick.
  - On the tick where the counter reaches ATTACK_FRAMES-1: sword_visible<=0, attacking<=0, cooldown<=COOLDOWN_FRAMES, -> IDLE.
  - Attack press during ATTACK or while cooldown>0 is ignored, not queued.
- Cooldown: decrements once per tick, saturating at 0.
- Sprite:
  - In ATTACK, sprite=4'd4.
  - In IDLE, an anim counter counts 0..ANIM_PERIOD-1; sprite toggles 2<->3 at wrap. The counter keeps running through ATTACK.
- Respawn:
  - spawn_valid=1 (any clk, with or without trigger) loads spawn_x/spawn_y unchecked.
  - It also clears sword_visible/attacking, forces IDLE, and zeroes the cooldown, hold and attack counters.
  - spawn_valid wins over a same-cycle trigger action. reset wins over spawn_valid.
- Mid-attack reset or respawn: sword disappears the next clk; no cooldown applied.

Test Plan:
- Reset, then 3 idle ticks -> pos (1,3), direction 01, sword_visible 0, sprite 2; after 8 ticks sprite 3.
- Tap up at pos (1,3) for 1 tick, release -> pos (1,2), direction 00; next tap up -> (1,1); further tap up -> stays (1,1), direction 00.
- Hold right 14 ticks from (1,3) -> x steps at tick 0, tick 8, tick 11 => x=4; release, no further motion.
- Press attack + left at (5,5) -> sword (4,5), orientation 11, visible for exactly 3 ticks. Attack press during the next 4 ticks is ignored; press on tick 5 after -> new attack.
- Attack facing left at x=0 -> attacking=1 for 3 ticks, sword_visible stays 0.
- spawn_valid with (7,9) mid-attack, no trigger -> next clk pos (7,9), sword_visible 0, attacking 0; immediate attack press on next tick accepted.

Source files
------------

// File: rtl/player_ctrl_grid.sv
// Single-player grid controller: position, facing, sword, cooldown, hold-to-repeat
// movement and idle animation, all advanced by the frame tick; respawn acts on any clock.
module player_ctrl_grid #(
   parameter int GRID_W          = 16,
   parameter int GRID_H          = 12,
   parameter int Y_MIN           = 1,
   parameter int XW              = 4,
   parameter int YW              = 4,
   parameter int ATTACK_FRAMES   = 3,
   parameter int COOLDOWN_FRAMES = 4,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_RATE     = 3,
   parameter int ANIM_PERIOD     = 8,
   parameter int SPAWN_X         = 1,
   parameter int SPAWN_Y         = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          trigger,
   input  logic [4:0]    btn,
   input  logic          spawn_valid,
   input  logic [XW-1:0] spawn_x,
   input  logic [YW-1:0] spawn_y,
   output logic [XW-1:0] player_x,
   output logic [YW-1:0] player_y,
   output logic [1:0]    player_orientation,
   output logic [1:0]    player_direction,
   output logic [3:0]    player_sprite,
   output logic [XW-1:0] sword_x,
   output logic [YW-1:0] sword_y,
   output logic          sword_visible,
   output logic [1:0]    sword_orientation,
   output logic          attacking
);

   localparam int unsigned HW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
   localparam int unsigned AW = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES) : 1;
   localparam int unsigned CW = $clog2(COOLDOWN_FRAMES + 2);
   localparam int unsigned NW = $clog2(ANIM_PERIOD + 1);

   localparam logic [HW-1:0] HOLD_FIRE = HW'(REPEAT_DELAY);
   localparam logic [HW-1:0] HOLD_WRAP = HW'(REPEAT_DELAY + REPEAT_RATE);
   localparam logic [AW-1:0] ATK_LAST  = AW'(ATTACK_FRAMES - 1);
   localparam logic [CW-1:0] COOL_INIT = CW'(COOLDOWN_FRAMES);
   localparam logic [NW-1:0] ANIM_LAST = NW'(ANIM_PERIOD - 1);

   typedef enum logic {S_IDLE = 1'b0, S_ATTACK = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] player_x_q, player_x_d;
   logic [YW-1:0] player_y_q, player_y_d;
   logic [1:0]    orient_q, orient_d;
   logic [1:0]    dir_q, dir_d;
   logic [3:0]    sprite_q, sprite_d;
   logic [XW-1:0] sword_x_q, sword_x_d;
   logic [YW-1:0] sword_y_q, sword_y_d;
   logic          sword_vis_q, sword_vis_d;
   logic [1:0]    sword_orient_q, sword_orient_d;
   logic          attacking_q, attacking_d;
   logic [4:0]    btn_prev_q, btn_prev_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [AW-1:0] atk_q, atk_d;
   logic [CW-1:0] cool_q, cool_d;
   logic [NW-1:0] anim_q, anim_d;
   logic          idle_frame_q, idle_frame_d;

   logic [4:0]    press_c;
   logic [1:0]    held_dir_c, press_dir_c, move_dir_c, face_c, act_dir_c;
   logic          held_any_c, hold_same_c, repeat_fire_c, attack_go_c, move_go_c, tgt_ok_c;
   logic [HW-1:0] hold_inc_c, hold_next_c;
   int            tx_c, ty_c;

   assign player_x           = player_x_q;
   assign player_y           = player_y_q;
   assign player_orientation = orient_q;
   assign player_direction   = dir_q;
   assign player_sprite      = sprite_q;
   assign sword_x            = sword_x_q;
   assign sword_y            = sword_y_q;
   assign sword_visible      = sword_vis_q;
   assign sword_orientation  = sword_orient_q;
   assign attacking          = attacking_q;

   // Priority up > down > left > right; returns direction code.
   function automatic logic [1:0] prio_dir(input logic [3:0] b);
      if (b[0])      return 2'b00;
      else if (b[1]) return 2'b10;
      else if (b[2]) return 2'b11;
      else           return 2'b01;
   endfunction

   // Button edges, auto-repeat timing and the action direction for this tick.
   always_comb begin
      press_c     = btn & ~btn_prev_q;
      held_any_c  = |btn[3:0];
      held_dir_c  = prio_dir(btn[3:0]);
      press_dir_c = prio_dir(press_c[3:0]);
      face_c      = held_any_c ? held_dir_c : dir_q;
      hold_same_c = $onehot(btn[3:0]) && (btn[3:0] == btn_prev_q[3:0]);
      hold_inc_c  = hold_q + 1'b1;
      if (!hold_same_c)              hold_next_c = '0;
      else if (hold_inc_c == HOLD_WRAP) hold_next_c = HOLD_FIRE;
      else                           hold_next_c = hold_inc_c;
      repeat_fire_c = hold_same_c && (hold_next_c == HOLD_FIRE);
      attack_go_c   = (state_q == S_IDLE) && press_c[4] && (cool_q == '0);
      move_go_c     = (|press_c[3:0]) || repeat_fire_c;
      move_dir_c    = (|press_c[3:0]) ? press_dir_c : held_dir_c;
      act_dir_c     = attack_go_c ? face_c : move_dir_c;
   end

   // Neighbour cell in the action direction, evaluated wide so edges never wrap.
   always_comb begin
      tx_c = int'(player_x_q);
      ty_c = int'(player_y_q);
      case (act_dir_c)
         2'b00:   ty_c = ty_c - 1;
         2'b01:   tx_c = tx_c + 1;
         2'b10:   ty_c = ty_c + 1;
         default: tx_c = tx_c - 1;
      endcase
      tgt_ok_c = (tx_c >= 0) && (tx_c < GRID_W) && (ty_c >= Y_MIN) && (ty_c < GRID_H);
   end

   always_comb begin
      state_d        = state_q;
      player_x_d     = player_x_q;
      player_y_d     = player_y_q;
      orient_d       = orient_q;
      dir_d          = dir_q;
      sword_x_d      = sword_x_q;
      sword_y_d      = sword_y_q;
      sword_vis_d    = sword_vis_q;
      sword_orient_d = sword_orient_q;
      attacking_d    = attacking_q;
      btn_prev_d     = btn_prev_q;
      hold_d         = hold_q;
      atk_d          = atk_q;
      cool_d         = cool_q;
      anim_d         = anim_q;
      idle_frame_d   = idle_frame_q;

      if (spawn_valid) begin
         player_x_d  = spawn_x;
         player_y_d  = spawn_y;
         sword_vis_d = 1'b0;
         attacking_d = 1'b0;
         state_d     = S_IDLE;
         cool_d      = '0;
         hold_d      = '0;
         atk_d       = '0;
      end else if (trigger) begin
         btn_prev_d = btn;
         hold_d     = hold_next_c;
         cool_d     = (cool_q != '0) ? cool_q - 1'b1 : '0;
         if (anim_q == ANIM_LAST) begin
            anim_d       = '0;
            idle_frame_d = ~idle_frame_q;
         end else begin
            anim_d = anim_q + 1'b1;
         end

         if (state_q == S_IDLE) begin
            if (attack_go_c) begin
               state_d        = S_ATTACK;
               dir_d          = face_c;
               if (face_c[0]) orient_d = face_c;
               sword_x_d      = XW'(tx_c);
               sword_y_d      = YW'(ty_c);
               sword_vis_d    = tgt_ok_c;
               sword_orient_d = face_c;
               attacking_d    = 1'b1;
               atk_d          = '0;
            end else if (move_go_c) begin
               dir_d = move_dir_c;
               if (move_dir_c[0]) orient_d = move_dir_c;
               if (tgt_ok_c) begin
                  player_x_d = XW'(tx_c);
                  player_y_d = YW'(ty_c);
               end
            end
         end else begin
            if (atk_q == ATK_LAST) begin
               state_d     = S_IDLE;
               sword_vis_d = 1'b0;
               attacking_d = 1'b0;
               cool_d      = COOL_INIT;
            end else begin
               atk_d = atk_q + 1'b1;
            end
         end
      end

      sprite_d = (state_d == S_ATTACK) ? 4'd4 : (idle_frame_d ? 4'd3 : 4'd2);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         player_x_q     <= XW'(SPAWN_X);
         player_y_q     <= YW'(SPAWN_Y);
         orient_q       <= 2'b01;
         dir_q          <= 2'b01;
         sprite_q       <= 4'd2;
         sword_x_q      <= '0;
         sword_y_q      <= '0;
         sword_vis_q    <= 1'b0;
         sword_orient_q <= 2'b01;
         attacking_q    <= 1'b0;
         btn_prev_q     <= '0;
         hold_q         <= '0;
         atk_q          <= '0;
         cool_q         <= '0;
         anim_q         <= '0;
         idle_frame_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         player_x_q     <= player_x_d;
         player_y_q     <= player_y_d;
         orient_q       <= orient_d;
         dir_q          <= dir_d;
         sprite_q       <= sprite_d;
         sword_x_q      <= sword_x_d;
         sword_y_q      <= sword_y_d;
         sword_vis_q    <= sword_vis_d;
         sword_orient_q <= sword_orient_d;
         attacking_q    <= attacking_d;
         btn_prev_q     <= btn_prev_d;
         hold_q         <= hold_d;
         atk_q          <= atk_d;
         cool_q         <= cool_d;
         anim_q         <= anim_d;
         idle_frame_q   <= idle_frame_d;
      end
   end

endmodule

// File: tb/tb_player_ctrl_grid.sv
// Bench for player_ctrl_grid: directed scenarios then randomized buttons/ticks/respawns,
// all compared against a tick-level behavioural model of the player.
module tb_player_ctrl_grid;

   localparam int GRID_W          = 16;
   localparam int GRID_H          = 12;
   localparam int Y_MIN           = 1;
   localparam int ATTACK_FRAMES   = 3;
   localparam int COOLDOWN_FRAMES = 4;
   localparam int REPEAT_DELAY    = 8;
   localparam int REPEAT_RATE     = 3;
   localparam int ANIM_PERIOD     = 8;

   localparam logic [4:0] B_UP    = 5'b00001;
   localparam logic [4:0] B_LEFT  = 5'b00100;
   localparam logic [4:0] B_RIGHT = 5'b01000;
   localparam logic [4:0] B_ATK   = 5'b10000;

   logic       clk = 1'b0;
   logic       reset;
   logic       trigger;
   logic [4:0] btn;
   logic       spawn_valid;
   logic [3:0] spawn_x, spawn_y;
   logic [3:0] player_x, player_y, sword_x, sword_y, player_sprite;
   logic [1:0] player_orientation, player_direction, sword_orientation;
   logic       sword_visible, attacking;

   always #5 clk = ~clk;

   player_ctrl_grid dut (
      .clk(clk), .reset(reset), .trigger(trigger), .btn(btn),
      .spawn_valid(spawn_valid), .spawn_x(spawn_x), .spawn_y(spawn_y),
      .player_x(player_x), .player_y(player_y),
      .player_orientation(player_orientation), .player_direction(player_direction),
      .player_sprite(player_sprite), .sword_x(sword_x), .sword_y(sword_y),
      .sword_visible(sword_visible), .sword_orientation(sword_orientation),
      .attacking(attacking)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int         mx, my, m_dir, m_orient, m_swx, m_swy, m_vis, m_swor, m_att;
   int         m_atk_rem, m_cool, m_hold, m_anim;
   logic [4:0] m_prev;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic int prio(input logic [3:0] b);
      if (b[0]) return 0;
      if (b[1]) return 2;
      if (b[2]) return 3;
      return 1;
   endfunction

   function automatic bit in_grid(input int tx, input int ty);
      return tx >= 0 && tx <= GRID_W - 1 && ty >= Y_MIN && ty <= GRID_H - 1;
   endfunction

   task automatic target(input int d, output int tx, output int ty);
      tx = mx;
      ty = my;
      case (d)
         0:       ty = ty - 1;
         1:       tx = tx + 1;
         2:       ty = ty + 1;
         default: tx = tx - 1;
      endcase
   endtask

   task automatic model_reset();
      mx = 1; my = 3; m_dir = 1; m_orient = 1; m_swx = 0; m_swy = 0; m_vis = 0; m_swor = 1;
      m_att = 0; m_atk_rem = 0; m_cool = 0; m_hold = 0; m_anim = 0; m_prev = '0;
   endtask

   task automatic model_spawn(input int sx, input int sy);
      mx = sx; my = sy; m_vis = 0; m_att = 0; m_atk_rem = 0; m_cool = 0; m_hold = 0;
   endtask

   task automatic model_tick(input logic [4:0] b);
      logic [4:0] old, p;
      int  cool_was, d, tx, ty;
      bit  same, fire;
      old    = m_prev;
      p      = b & ~old;
      m_prev = b;
      same   = ($countones(b[3:0]) == 1) && (b[3:0] == old[3:0]);
      m_hold = same ? m_hold + 1 : 0;
      fire   = same && (m_hold >= REPEAT_DELAY) && ((m_hold - REPEAT_DELAY) % REPEAT_RATE == 0);
      m_anim++;
      cool_was = m_cool;
      if (m_cool > 0) m_cool--;
      if (m_atk_rem > 0) begin
         m_atk_rem--;
         if (m_atk_rem == 0) begin
            m_vis = 0; m_att = 0; m_cool = COOLDOWN_FRAMES;
         end
      end else if (p[4] && cool_was == 0) begin
         d = (b[3:0] != 0) ? prio(b[3:0]) : m_dir;
         m_dir = d;
         if (d == 1 || d == 3) m_orient = d;
         target(d, tx, ty);
         m_swx = tx; m_swy = ty; m_vis = in_grid(tx, ty) ? 1 : 0;
         m_swor = d; m_att = 1; m_atk_rem = ATTACK_FRAMES;
      end else if (p[3:0] != 0 || fire) begin
         d = (p[3:0] != 0) ? prio(p[3:0]) : prio(b[3:0]);
         m_dir = d;
         if (d == 1 || d == 3) m_orient = d;
         target(d, tx, ty);
         if (in_grid(tx, ty)) begin
            mx = tx; my = ty;
         end
      end
   endtask

   task automatic check_all();
      chk("player_x", int'(player_x), mx);
      chk("player_y", int'(player_y), my);
      chk("direction", int'(player_direction), m_dir);
      chk("orientation", int'(player_orientation), m_orient);
      chk("sword_visible", int'(sword_visible), m_vis);
      chk("attacking", int'(attacking), m_att);
      chk("sword_orientation", int'(sword_orientation), m_swor);
      chk("sprite", int'(player_sprite), m_att != 0 ? 4 : (((m_anim / ANIM_PERIOD) % 2) != 0 ? 3 : 2));
      if (m_vis != 0) begin
         chk("sword_x", int'(sword_x), m_swx);
         chk("sword_y", int'(sword_y), m_swy);
      end
   endtask

   task automatic do_cycle(input logic trig, input logic [4:0] b, input logic sv,
                           input logic [3:0] sx, input logic [3:0] sy);
      @(negedge clk);
      trigger = trig; btn = b; spawn_valid = sv; spawn_x = sx; spawn_y = sy;
      @(posedge clk);
      if (sv) model_spawn(int'(sx), int'(sy));
      else if (trig) model_tick(b);
      #1;
      check_all();
   endtask

   task automatic tick(input logic [4:0] b);
      do_cycle(1'b1, b, 1'b0, 4'd0, 4'd0);
   endtask

   task automatic respawn(input logic [3:0] sx, input logic [3:0] sy);
      do_cycle(1'b0, 5'b0, 1'b1, sx, sy);
   endtask

   initial begin
      logic [4:0] b;
      logic       trig, sv;
      logic [3:0] sx, sy;
      int         r;

      reset = 1'b0; trigger = 1'b0; btn = '0; spawn_valid = 1'b0; spawn_x = '0; spawn_y = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_x", int'(player_x), 1);
      chk("rst_y", int'(player_y), 3);
      chk("rst_dir", int'(player_direction), 1);
      chk("rst_orient", int'(player_orientation), 1);
      chk("rst_sprite", int'(player_sprite), 2);
      chk("rst_sword_xy", int'({sword_x, sword_y}), 0);
      chk("rst_sword_vis", int'(sword_visible), 0);
      chk("rst_sword_or", int'(sword_orientation), 1);
      chk("rst_attacking", int'(attacking), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;

      // Idle animation
      repeat (3) tick(5'b0);
      chk("idle3_sprite", int'(player_sprite), 2);
      repeat (5) tick(5'b0);
      chk("idle8_sprite", int'(player_sprite), 3);

      // Tap up into the top boundary
      tick(B_UP);
      chk("tap_up_y", int'(player_y), 2);
      chk("tap_up_dir", int'(player_direction), 0);
      tick(5'b0);
      tick(B_UP);
      chk("tap_up2_y", int'(player_y), 1);
      tick(5'b0);
      tick(B_UP);
      chk("tap_up_blocked_y", int'(player_y), 1);
      chk("tap_up_blocked_dir", int'(player_direction), 0);
      tick(5'b0);

      // Hold right with auto-repeat
      respawn(4'd1, 4'd3);
      repeat (14) tick(B_RIGHT);
      chk("hold_right_x", int'(player_x), 4);
      repeat (5) tick(5'b0);
      chk("released_x", int'(player_x), 4);

      // Attack left, visibility length and cooldown
      respawn(4'd5, 4'd5);
      tick(B_ATK | B_LEFT);
      chk("atk_sword_x", int'(sword_x), 4);
      chk("atk_sword_y", int'(sword_y), 5);
      chk("atk_sword_or", int'(sword_orientation), 3);
      chk("atk_vis", int'(sword_visible), 1);
      tick(5'b0);
      tick(5'b0);
      chk("atk_vis_tick3", int'(sword_visible), 1);
      tick(5'b0);
      chk("atk_end_vis", int'(sword_visible), 0);
      chk("atk_end_attacking", int'(attacking), 0);
      tick(B_ATK);
      chk("cool_ignore1", int'(attacking), 0);
      tick(5'b0);
      tick(B_ATK);
      chk("cool_ignore3", int'(attacking), 0);
      tick(5'b0);
      tick(B_ATK);
      chk("cool_done_attack", int'(attacking), 1);
      repeat (3) tick(5'b0);

      // Attack off the left edge
      respawn(4'd0, 4'd4);
      tick(B_ATK | B_LEFT);
      chk("edge_atk_attacking", int'(attacking), 1);
      chk("edge_atk_vis", int'(sword_visible), 0);
      tick(5'b0);
      tick(5'b0);
      chk("edge_atk_attacking3", int'(attacking), 1);
      tick(5'b0);
      chk("edge_atk_end", int'(attacking), 0);

      // Respawn in the middle of an attack
      respawn(4'd3, 4'd3);
      tick(B_ATK | B_UP);
      chk("mid_atk_vis", int'(sword_visible), 1);
      tick(5'b0);
      respawn(4'd7, 4'd9);
      chk("respawn_x", int'(player_x), 7);
      chk("respawn_y", int'(player_y), 9);
      chk("respawn_vis", int'(sword_visible), 0);
      chk("respawn_attacking", int'(attacking), 0);
      tick(B_ATK);
      chk("respawn_reattack", int'(attacking), 1);
      repeat (4) tick(5'b0);

      // Randomized traffic
      b = '0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 6) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)      b = '0;
            else if (r < 7) b = 5'(1 << $urandom_range(0, 3));
            else if (r < 8) b = B_ATK | 5'(1 << $urandom_range(0, 3));
            else            b = 5'($urandom);
         end
         if ($urandom_range(0, 99) < 10) b[4] = ~b[4];
         trig = ($urandom_range(0, 99) < 60);
         sv   = ($urandom_range(0, 99) < 2);
         sx   = 4'($urandom_range(0, 15));
         sy   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 11));
         do_cycle(trig, b, sv, sx, sy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
